// File: rtl/memory_arbiter.sv
// Two-port (CPU/DMA) arbiter in front of a single fixed-latency memory.
// Round-robin on ties, one access in flight, all outputs registered.
module memory_arbiter #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int MEM_LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ready,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              grant_dma
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state;
  logic [2:0]        cnt;
  logic              last_grant;
  logic              winner;
  logic              we_latched;

  logic              pick_dma;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // On a tie the port that was not served last time wins.
  assign pick_dma  = dma_req && (!cpu_req || !last_grant);
  assign sel_we    = pick_dma ? dma_we    : cpu_we;
  assign sel_addr  = pick_dma ? dma_addr  : cpu_addr;
  assign sel_wdata = pick_dma ? dma_wdata : cpu_wdata;

  // mem_addr/mem_wdata double as the latched request for the whole ACCESS phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 3'd0;
      last_grant <= 1'b1;
      winner     <= 1'b0;
      we_latched <= 1'b0;
      cpu_ready  <= 1'b0;
      dma_ready  <= 1'b0;
      cpu_rdata  <= '0;
      dma_rdata  <= '0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
      grant_dma  <= 1'b0;
    end else begin
      cpu_ready <= 1'b0;
      dma_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req || dma_req) begin
            winner     <= pick_dma;
            we_latched <= sel_we;
            cnt        <= 3'(MEM_LATENCY - 1);
            state      <= ACCESS;
            busy       <= 1'b1;
            grant_dma  <= pick_dma;
            mem_read   <= !sel_we;
            mem_write  <= sel_we;
            mem_addr   <= sel_addr;
            mem_wdata  <= sel_wdata;
          end
        end
        ACCESS: begin
          if (cnt != 3'd0) begin
            cnt <= cnt - 3'd1;
          end else begin
            if (!we_latched) begin
              if (winner) dma_rdata <= mem_rdata;
              else        cpu_rdata <= mem_rdata;
            end
            state     <= RESP;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_ready <= !winner;
            dma_ready <= winner;
          end
        end
        RESP: begin
          last_grant <= winner;
          state      <= IDLE;
          busy       <= 1'b0;
          grant_dma  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: one instance at latency 2, one at latency 1.
module tb_memory_arbiter;
  localparam int DW = 16;
  localparam int AW = 16;

  logic clk = 0;
  logic reset;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  logic          cpu_req, cpu_we, dma_req, dma_we;
  logic [AW-1:0] cpu_addr, dma_addr, mem_addr;
  logic [DW-1:0] cpu_wdata, dma_wdata, cpu_rdata, dma_rdata, mem_wdata, mem_rdata;
  logic          cpu_ready, dma_ready, mem_read, mem_write, busy, grant_dma;

  logic          b_cpu_req, b_cpu_we, b_dma_req, b_dma_we;
  logic [AW-1:0] b_cpu_addr, b_dma_addr, b_mem_addr;
  logic [DW-1:0] b_cpu_wdata, b_dma_wdata, b_cpu_rdata, b_dma_rdata, b_mem_wdata, b_mem_rdata;
  logic          b_cpu_ready, b_dma_ready, b_mem_read, b_mem_write, b_busy, b_grant_dma;

  memory_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MEM_LATENCY(2)) u_a (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ready(dma_ready), .dma_rdata(dma_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .grant_dma(grant_dma)
  );

  memory_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MEM_LATENCY(1)) u_b (
    .clk(clk), .reset(reset),
    .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
    .cpu_ready(b_cpu_ready), .cpu_rdata(b_cpu_rdata),
    .dma_req(b_dma_req), .dma_we(b_dma_we), .dma_addr(b_dma_addr), .dma_wdata(b_dma_wdata),
    .dma_ready(b_dma_ready), .dma_rdata(b_dma_rdata),
    .mem_read(b_mem_read), .mem_write(b_mem_write), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata),
    .busy(b_busy), .grant_dma(b_grant_dma)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string name);
    tests_run++;
    if ({cpu_ready, dma_ready, mem_read, mem_write, busy, grant_dma} !== 6'b0 ||
        mem_addr !== 16'h0 || mem_wdata !== 16'h0 ||
        cpu_rdata !== 16'h0 || dma_rdata !== 16'h0) begin
      tests_failed++;
      $display("FAIL %s: ctrl=%b addr=%h wdata=%h crd=%h drd=%h, expected all zero", name,
               {cpu_ready, dma_ready, mem_read, mem_write, busy, grant_dma},
               mem_addr, mem_wdata, cpu_rdata, dma_rdata);
    end
  endtask

  task automatic test_reset();
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0; mem_rdata = 0;
    b_cpu_req = 0; b_cpu_we = 0; b_cpu_addr = 0; b_cpu_wdata = 0;
    b_dma_req = 0; b_dma_we = 0; b_dma_addr = 0; b_dma_wdata = 0; b_mem_rdata = 0;
    reset = 1;
    step(); step();
    reset = 0;
    check_all_zero("reset_state");
    $display("[TB] reset done");
  endtask

  task automatic test_cpu_read();
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010; mem_rdata = 16'hDEAD;
    for (int c = 1; c <= 4; c++) begin
      step();
      if (c == 2) mem_rdata = 16'hBEEF;
      else        mem_rdata = 16'hDEAD;
      tests_run++;
      if (mem_read !== (c == 1 || c == 2) || cpu_ready !== (c == 3) || mem_write !== 1'b0) begin
        tests_failed++;
        $display("FAIL cpu_read_c%0d: mem_read=%b cpu_ready=%b mem_write=%b", c, mem_read, cpu_ready, mem_write);
      end
      if (c <= 2) begin
        tests_run++;
        if (mem_addr !== 16'h0010) begin
          tests_failed++;
          $display("FAIL cpu_read_addr: got %h expected 0010", mem_addr);
        end
      end
      if (c == 3) begin
        cpu_req = 0;
        tests_run++;
        if (cpu_rdata !== 16'hBEEF) begin
          tests_failed++;
          $display("FAIL cpu_read_data: got %h expected BEEF", cpu_rdata);
        end
      end
    end
    $display("[TB] cpu read 0010 -> %h", cpu_rdata);
  endtask

  task automatic test_arbitration();
    logic [11:0] exp_cpu, exp_dma, exp_grant, exp_busy;
    logic [AW-1:0] exp_addr;
    exp_cpu = 12'h808; exp_dma = 12'h080; exp_grant = 12'h0E0; exp_busy = 12'hEEE;
    reset = 1; step(); reset = 0;
    mem_rdata = 16'h5A5A;
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h000A;
    dma_req = 1; dma_we = 0; dma_addr = 16'h000B;
    for (int c = 1; c <= 11; c++) begin
      step();
      if (c == 1 || c == 2 || c == 9 || c == 10) exp_addr = 16'h000A;
      else if (c == 5 || c == 6)                exp_addr = 16'h000B;
      else                                      exp_addr = 16'h0000;
      tests_run++;
      if (cpu_ready !== exp_cpu[c] || dma_ready !== exp_dma[c] ||
          grant_dma !== exp_grant[c] || busy !== exp_busy[c] || mem_addr !== exp_addr) begin
        tests_failed++;
        $display("FAIL arb_c%0d: cr=%b dr=%b g=%b b=%b a=%h expected cr=%b dr=%b g=%b b=%b a=%h",
                 c, cpu_ready, dma_ready, grant_dma, busy, mem_addr,
                 exp_cpu[c], exp_dma[c], exp_grant[c], exp_busy[c], exp_addr);
      end
    end
    cpu_req = 0; dma_req = 0;
    step();
    tests_run++;
    if (cpu_rdata !== 16'h5A5A || dma_rdata !== 16'h5A5A || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL arb_end: crd=%h drd=%h busy=%b expected 5A5A 5A5A 0", cpu_rdata, dma_rdata, busy);
    end
    $display("[TB] arbitration cpu,dma,cpu done");
  endtask

  task automatic test_dma_write();
    dma_req = 1; dma_we = 1; dma_addr = 16'h0100; dma_wdata = 16'h1234;
    mem_rdata = 16'hFFFF;
    for (int c = 1; c <= 4; c++) begin
      step();
      tests_run++;
      if (mem_write !== (c <= 2) || mem_read !== 1'b0 || dma_ready !== (c == 3) ||
          cpu_ready !== 1'b0 || grant_dma !== (c <= 3)) begin
        tests_failed++;
        $display("FAIL dma_write_c%0d: mw=%b mr=%b dr=%b cr=%b g=%b", c, mem_write, mem_read,
                 dma_ready, cpu_ready, grant_dma);
      end
      if (c <= 2) begin
        tests_run++;
        if (mem_addr !== 16'h0100 || mem_wdata !== 16'h1234) begin
          tests_failed++;
          $display("FAIL dma_write_bus: addr=%h wdata=%h expected 0100 1234", mem_addr, mem_wdata);
        end
      end
      if (c == 3) dma_req = 0;
    end
    tests_run++;
    if (dma_rdata !== 16'h5A5A) begin
      tests_failed++;
      $display("FAIL dma_write_rdata: got %h expected 5A5A", dma_rdata);
    end
    dma_we = 0;
    $display("[TB] dma write 0100 <= 1234");
  endtask

  task automatic test_reset_abort();
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0020; mem_rdata = 16'h4444;
    step();
    tests_run++;
    if (mem_read !== 1'b1) begin
      tests_failed++;
      $display("FAIL abort_access: mem_read=%b expected 1", mem_read);
    end
    reset = 1; cpu_req = 0;
    step();
    reset = 0;
    check_all_zero("abort_outputs");
    for (int c = 0; c < 3; c++) begin
      step();
      tests_run++;
      if (cpu_ready !== 1'b0 || busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL abort_no_ready: cpu_ready=%b busy=%b expected 0 0", cpu_ready, busy);
      end
    end
    cpu_req = 1; cpu_addr = 16'h0021; dma_req = 1; dma_addr = 16'h0022;
    step();
    tests_run++;
    if (grant_dma !== 1'b0 || mem_addr !== 16'h0021) begin
      tests_failed++;
      $display("FAIL abort_tie: grant_dma=%b addr=%h expected 0 0021", grant_dma, mem_addr);
    end
    cpu_req = 0; dma_req = 0;
    step(); step(); step();
    $display("[TB] reset abort then tie grants cpu");
  endtask

  task automatic test_req_drop();
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0030; mem_rdata = 16'h7777;
    step();
    cpu_req = 0;
    step(); step();
    tests_run++;
    if (cpu_ready !== 1'b1 || cpu_rdata !== 16'h7777) begin
      tests_failed++;
      $display("FAIL req_drop_ready: cpu_ready=%b rdata=%h expected 1 7777", cpu_ready, cpu_rdata);
    end
    for (int c = 0; c < 2; c++) begin
      step();
      tests_run++;
      if (busy !== 1'b0 || cpu_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL req_drop_idle: busy=%b cpu_ready=%b expected 0 0", busy, cpu_ready);
      end
    end
    $display("[TB] cpu req dropped mid-access completed");
  endtask

  task automatic test_latency1();
    reset = 1; step(); reset = 0;
    b_cpu_req = 1; b_cpu_we = 0; b_cpu_addr = 16'h0040; b_mem_rdata = 16'h1000;
    for (int c = 1; c <= 9; c++) begin
      step();
      tests_run++;
      if (b_cpu_ready !== (c % 3 == 2) || b_mem_read !== (c % 3 == 1)) begin
        tests_failed++;
        $display("FAIL lat1_c%0d: ready=%b mem_read=%b expected %b %b", c, b_cpu_ready, b_mem_read,
                 (c % 3 == 2), (c % 3 == 1));
      end
      if (c % 3 == 2) begin
        tests_run++;
        if (b_cpu_rdata !== DW'(16'h1000 + c - 1)) begin
          tests_failed++;
          $display("FAIL lat1_data_c%0d: got %h expected %h", c, b_cpu_rdata, DW'(16'h1000 + c - 1));
        end
      end
      b_mem_rdata = DW'(16'h1000 + c);
    end
    b_cpu_req = 0;
    $display("[TB] latency-1 back-to-back reads done");
  endtask

  initial begin
    reset = 1;
    test_reset();
    test_cpu_read();
    test_arbitration();
    test_dma_write();
    test_reset_abort();
    test_req_drop();
    test_latency1();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter DATA_W, default 16, memory data width in bits.
REQ-002 Parameter ADDR_W, default 16, memory address width in bits.
REQ-003 Parameter MEM_LATENCY, default 2, memory access cycles; legal range 1..7.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 cpu_req  input  1  CPU access request; held until cpu_ready.
REQ-007 cpu_we  input  1  CPU access type: 1 write, 0 read.
REQ-008 cpu_addr  input  ADDR_W  CPU access address.
REQ-009 cpu_wdata  input  DATA_W  CPU write data.
REQ-010 cpu_ready  output  1  one-cycle CPU completion pulse.
REQ-011 cpu_rdata  output  DATA_W  CPU read data, registered.
REQ-012 dma_req, dma_we, dma_addr, dma_wdata, dma_ready, dma_rdata  same directions/widths as CPU set  DMA port.
REQ-013 mem_read  output  1  memory read strobe.
REQ-014 mem_write  output  1  memory write strobe.
REQ-015 mem_addr  output  ADDR_W  memory address.
REQ-016 mem_wdata  output  DATA_W  memory write data.
REQ-017 mem_rdata  input  DATA_W  memory read data, valid in last ACCESS cycle.
REQ-018 busy  output  1  high whenever state is not IDLE.
REQ-019 grant_dma  output  1  high in ACCESS/RESP when DMA is the served port.

Function
REQ-020 States IDLE, ACCESS, RESP; 3-bit down-counter cnt; 1-bit last_grant (0 CPU, 1 DMA).
REQ-021 Requests sampled only in IDLE; req changes during ACCESS/RESP ignored.
REQ-022 IDLE, one req high: that port wins; both high: port not equal to last_grant wins; none: stay IDLE.
REQ-023 On win: latch winner's addr, we, wdata; cnt <= MEM_LATENCY-1; next state ACCESS.
REQ-024 ACCESS: mem_addr/mem_wdata driven from latched values; mem_read = !we_latched, mem_write = we_latched, held every ACCESS cycle.
REQ-025 ACCESS with cnt != 0: cnt decrements, stay ACCESS.
REQ-026 ACCESS with cnt == 0: read captures mem_rdata into winner's rdata register; next state RESP.
REQ-027 RESP: winner's ready = 1 for exactly one cycle; last_grant <= winner; next state IDLE.
REQ-028 Latency: req sampled in cycle N -> ready in cycle N+MEM_LATENCY+1; throughput one access per MEM_LATENCY+2 cycles.
REQ-029 Outside ACCESS: mem_read = mem_write = 0, mem_addr = mem_wdata = 0.
REQ-030 Never both strobes high; never both ready high; loser's ready stays 0.
REQ-031 cpu_rdata/dma_rdata change only on completion of a read for that port; writes leave them unchanged.
REQ-032 Requester deasserting req mid-transaction: access still completes, ready still pulses.
REQ-033 Requester holding req through cycle after ready: treated as new request and arbitrated normally.
REQ-034 MEM_LATENCY = 1: exactly one ACCESS cycle.

Reset
REQ-035 reset high at a clock edge: state <= IDLE, cnt <= 0, last_grant <= 1 (CPU wins first tie), cpu_rdata = dma_rdata = 0, latched addr/we/wdata cleared.
REQ-036 All outputs 0 in the cycle after a reset edge; reset overrides every transition.
REQ-037 Reset during ACCESS/RESP: transaction aborted, strobes drop next cycle, no ready pulse issued.

Verification
REQ-038 MEM_LATENCY=2, CPU read addr 0x0010, mem_rdata=0xBEEF in last ACCESS cycle -> mem_read high cycles 1-2, cpu_ready pulse cycle 3, cpu_rdata=0xBEEF.
REQ-039 Both req high after reset, both held -> CPU served first, DMA second, CPU third; grant_dma 0,1,0; no overlap of ready pulses.
REQ-040 DMA write addr 0x0100 data 0x1234 -> mem_write high 2 cycles, mem_addr=0x0100, mem_wdata=0x1234, dma_ready pulse, dma_rdata unchanged.
REQ-041 Reset asserted in first ACCESS cycle of CPU read -> next cycle all outputs 0, busy 0, no cpu_ready; following tie grants CPU.
REQ-042 MEM_LATENCY=1, back-to-back CPU reads, req held -> ready every 3 cycles, mem_read high 1 cycle each.
REQ-043 CPU req dropped in ACCESS -> access completes, cpu_ready still pulses, arbiter then returns IDLE.
